// File: rtl/alu_op_pkg.sv
// rtl/alu_op_pkg.sv - opcode values shared by the ALU and the execution sequencer
package alu_op_pkg;
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_INC = 4'h3;
    localparam logic [3:0] OP_DEC = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_LD  = 4'hB;
    localparam logic [3:0] OP_ST  = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;
    localparam logic [3:0] OP_RTN = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;
endpackage

// File: rtl/exec_sequencer_pkg.sv
// rtl/exec_sequencer_pkg.sv - sequencer FSM states and instruction field layout
package exec_sequencer_pkg;
    import alu_op_pkg::*;

    // Instruction word: opcode sits directly above an imm field of ALU width.
    localparam int OPC_W   = 4;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_HALT
    } seq_state_t;

    function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_AND, OP_OR,
            OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_LD, OP_ST: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/exec_sequencer_ret_stack.sv
// rtl/exec_sequencer_ret_stack.sv - LIFO of return addresses for JMP/RTN
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_top,
    output logic         o_full,
    output logic         o_empty
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] w_top_idx;

    assign w_top_idx = IDX_W'(r_count - 1'b1);
    assign o_top     = r_mem[w_top_idx];
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_push && !o_full) begin
            r_mem[IDX_W'(r_count)] <= i_data;
            r_count                <= r_count + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - 1'b1;
        end
    end
endmodule

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - three-cycle fetch/decode/execute core driving an external ALU
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int SIZE        = 8,
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    output logic [PC_W-1:0]       instr_addr,
    input  logic [SIZE+OPC_W-1:0] instr_data,
    output logic                  alu_CE,
    output logic [OPC_W-1:0]      alu_OP_CODE,
    output logic [SIZE-1:0]       alu_left,
    output logic [SIZE-1:0]       alu_right,
    output logic                  alu_carry_in,
    input  logic [SIZE-1:0]       alu_op_out,
    input  logic                  alu_carry_out,
    output logic                  st_we,
    output logic [SIZE-1:0]       st_addr,
    output logic [SIZE-1:0]       st_data,
    output logic [SIZE-1:0]       acc,
    output logic                  carry_flag,
    output logic                  zero_flag,
    output logic                  halted,
    output logic                  stack_err
);
    import alu_op_pkg::*;

    localparam int OPC_LSB = SIZE;

    seq_state_t             r_state, w_state_next;
    logic [PC_W-1:0]        r_pc, w_pc_next, w_pc_inc, w_stack_top;
    logic [SIZE+OPC_W-1:0]  r_ir;
    logic [SIZE-1:0]        r_acc;
    logic                   r_c, r_z, r_stack_err;
    logic [OPC_W-1:0]       w_opcode;
    logic [SIZE-1:0]        w_imm;
    logic                   w_exec, w_alu_ce, w_commit_alu;
    logic                   w_push, w_pop, w_set_err, w_full, w_empty;

    assign w_opcode     = r_ir[OPC_LSB +: OPC_W];
    assign w_imm        = r_ir[IMM_LSB +: SIZE];
    assign w_pc_inc     = r_pc + 1'b1;
    assign w_exec       = (r_state == S_EXECUTE);
    assign w_alu_ce     = w_exec && is_alu_op(w_opcode);
    assign w_commit_alu = w_alu_ce && (w_opcode != OP_ST);

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_ret_stack (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_stack_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_FETCH;
                    w_pc_next    = '0;
                end
            end
            S_FETCH:  w_state_next = S_DECODE;
            S_DECODE: w_state_next = S_EXECUTE;
            S_EXECUTE: begin
                w_state_next = S_FETCH;
                w_pc_next    = w_pc_inc;
                case (w_opcode)
                    // Stack faults stop the core with PC left on the offending instruction.
                    OP_JMP: begin
                        if (w_full) begin
                            w_set_err    = 1'b1;
                            w_state_next = S_HALT;
                            w_pc_next    = r_pc;
                        end else begin
                            w_push    = 1'b1;
                            w_pc_next = w_imm[PC_W-1:0];
                        end
                    end
                    OP_RTN: begin
                        if (w_empty) begin
                            w_set_err    = 1'b1;
                            w_state_next = S_HALT;
                            w_pc_next    = r_pc;
                        end else begin
                            w_pop     = 1'b1;
                            w_pc_next = w_stack_top;
                        end
                    end
                    OP_HLT: begin
                        w_state_next = S_HALT;
                        w_pc_next    = r_pc;
                    end
                    default: ;
                endcase
            end
            S_HALT: ;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_ir        <= '0;
            r_acc       <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_stack_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (r_state == S_DECODE) begin
                r_ir <= instr_data;
            end
            if (w_commit_alu) begin
                r_acc <= alu_op_out;
                r_c   <= alu_carry_out;
                r_z   <= (alu_op_out == '0);
            end
            if (w_set_err) begin
                r_stack_err <= 1'b1;
            end
        end
    end

    assign instr_addr   = r_pc;
    assign alu_CE       = w_alu_ce;
    assign alu_OP_CODE  = w_opcode;
    assign alu_left     = r_acc;
    assign alu_right    = w_imm;
    assign alu_carry_in = r_c;
    assign st_we        = w_exec && (w_opcode == OP_ST);
    assign st_addr      = w_imm;
    assign st_data      = r_acc;
    assign acc          = r_acc;
    assign carry_flag   = r_c;
    assign zero_flag    = r_z;
    assign halted       = (r_state == S_HALT);
    assign stack_err    = r_stack_err;
endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - scoreboard bench: directed programs plus random ROMs vs a program-level model
module tb_exec_sequencer;
    import alu_op_pkg::*;

    localparam int SIZE  = 8;
    localparam int PC_W  = 8;
    localparam int DEPTH = 4;
    localparam int MAXI  = 64;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] l;
        logic [7:0] r;
        logic       cin;
    } alu_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } st_t;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            start = 1'b0;
    logic [PC_W-1:0] instr_addr;
    logic [SIZE+3:0] instr_data;
    logic            alu_CE;
    logic [3:0]      alu_OP_CODE;
    logic [SIZE-1:0] alu_left, alu_right, alu_op_out;
    logic            alu_carry_in, alu_carry_out;
    logic            st_we;
    logic [SIZE-1:0] st_addr, st_data, acc;
    logic            carry_flag, zero_flag, halted, stack_err;

    logic [11:0] rom [256];
    int          q_fetch [$];
    alu_t        q_alu [$];
    st_t         q_st [$];
    int          obs_fetch [$];

    int   n_cmp, n_bad;
    bit   mon_en;
    int   cyc, halt_cyc, st_cnt;
    bit   halt_seen;
    logic [7:0] last_st_addr, last_st_data;
    logic [7:0] exp_acc;
    logic       exp_c, exp_z, exp_err;
    int         exp_pc;

    exec_sequencer #(.SIZE(SIZE), .PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .start         (start),
        .instr_addr    (instr_addr),
        .instr_data    (instr_data),
        .alu_CE        (alu_CE),
        .alu_OP_CODE   (alu_OP_CODE),
        .alu_left      (alu_left),
        .alu_right     (alu_right),
        .alu_carry_in  (alu_carry_in),
        .alu_op_out    (alu_op_out),
        .alu_carry_out (alu_carry_out),
        .st_we         (st_we),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .acc           (acc),
        .carry_flag    (carry_flag),
        .zero_flag     (zero_flag),
        .halted        (halted),
        .stack_err     (stack_err)
    );

    always #5 CLK = ~CLK;

    // Environment ALU: {carry, result}; SUB/DEC carry is the borrow, shifts carry out the lost bit.
    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] l, input logic [7:0] r);
        case (op)
            OP_ADD:  return {1'b0, l} + {1'b0, r};
            OP_SUB:  return {1'b0, l} - {1'b0, r};
            OP_INC:  return {1'b0, l} + 9'd1;
            OP_DEC:  return {1'b0, l} - 9'd1;
            OP_AND:  return {1'b0, l & r};
            OP_OR:   return {1'b0, l | r};
            OP_XOR:  return {1'b0, l ^ r};
            OP_NOT:  return {1'b0, ~l};
            OP_SHL:  return {l, 1'b0};
            OP_SHR:  return {l[0], 1'b0, l[7:1]};
            OP_LD:   return {1'b0, r};
            default: return 9'd0;
        endcase
    endfunction

    always_comb {alu_carry_out, alu_op_out} = alu_f(alu_OP_CODE, alu_left, alu_right);

    always @(posedge CLK) instr_data <= rom[instr_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: DUT event did not match any expected one", name);
    endtask

    // Program-level reference: walks the ROM instruction by instruction.
    task automatic model_run(output int n, output bit halts);
        int         pc;
        int         stk [$];
        logic [7:0] a, imm;
        logic       c, z, e;
        logic [3:0] op;
        logic [8:0] res;
        alu_t       ax;
        st_t        sx;
        pc = 0; a = 0; c = 0; z = 0; e = 0; n = 0; halts = 0;
        q_fetch.delete(); q_alu.delete(); q_st.delete();
        while (!halts && n < MAXI) begin
            op  = rom[pc][11:8];
            imm = rom[pc][7:0];
            q_fetch.push_back(pc);
            n++;
            case (op)
                OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_AND, OP_OR,
                OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_LD, OP_ST: begin
                    ax.op = op; ax.l = a; ax.r = imm; ax.cin = c;
                    q_alu.push_back(ax);
                    if (op == OP_ST) begin
                        sx.addr = imm; sx.data = a;
                        q_st.push_back(sx);
                    end else begin
                        res = alu_f(op, a, imm);
                        a = res[7:0]; c = res[8]; z = (res[7:0] == 8'd0);
                    end
                    pc = (pc + 1) % 256;
                end
                OP_JMP: begin
                    if (stk.size() == DEPTH) begin e = 1; halts = 1; end
                    else begin stk.push_back((pc + 1) % 256); pc = imm; end
                end
                OP_RTN: begin
                    if (stk.size() == 0) begin e = 1; halts = 1; end
                    else pc = stk.pop_back();
                end
                OP_HLT:  halts = 1;
                default: pc = (pc + 1) % 256;
            endcase
        end
        exp_acc = a; exp_c = c; exp_z = z; exp_err = e; exp_pc = pc;
    endtask

    always @(negedge CLK) begin
        if (!mon_en) begin
            cyc = 0; halt_seen = 0; st_cnt = 0;
            obs_fetch.delete();
        end else begin
            alu_t ax;
            st_t  sx;
            int   fa;
            if (halted && !halt_seen) begin halt_seen = 1; halt_cyc = cyc; end
            if (!halted && (cyc % 3) == 0) begin
                obs_fetch.push_back(int'(instr_addr));
                if (q_fetch.size() == 0) fail_evt("fetch_extra");
                else begin fa = q_fetch.pop_front(); chk("fetch_addr", instr_addr, fa); end
            end
            if (alu_CE) begin
                if (q_alu.size() == 0) fail_evt("alu_ce_extra");
                else begin
                    ax = q_alu.pop_front();
                    chk("alu_op", alu_OP_CODE, ax.op);
                    chk("alu_left", alu_left, ax.l);
                    chk("alu_right", alu_right, ax.r);
                    chk("alu_cin", alu_carry_in, ax.cin);
                end
            end
            if (st_we) begin
                st_cnt++;
                last_st_addr = st_addr;
                last_st_data = st_data;
                if (q_st.size() == 0) fail_evt("st_we_extra");
                else begin
                    sx = q_st.pop_front();
                    chk("st_addr", st_addr, sx.addr);
                    chk("st_data", st_data, sx.data);
                end
            end
            cyc++;
        end
    end

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) rom[a] = {OP_HLT, 8'h00};
    endtask

    task automatic gen_random();
        logic [3:0] op;
        logic [7:0] imm;
        clear_rom();
        for (int a = 0; a < 16; a++) begin
            op  = 4'($urandom_range(0, 15));
            imm = 8'($urandom_range(0, 255));
            if (op == OP_JMP) imm = 8'($urandom_range(0, 15));
            rom[a] = {op, imm};
        end
    endtask

    task automatic do_reset(input bit check);
        mon_en = 0;
        start  = 0;
        @(negedge CLK);
        RST = 1;
        @(negedge CLK);
        if (check) begin
            chk("rst_addr", instr_addr, 0);
            chk("rst_acc", acc, 0);
            chk("rst_c", carry_flag, 0);
            chk("rst_z", zero_flag, 0);
            chk("rst_ce", alu_CE, 0);
            chk("rst_we", st_we, 0);
            chk("rst_halted", halted, 0);
            chk("rst_err", stack_err, 0);
        end
        RST = 0;
    endtask

    task automatic run_prog(input bit hold_start);
        int n;
        bit h;
        model_run(n, h);
        @(negedge CLK);
        start = 1;
        @(posedge CLK);
        #1;
        mon_en = 1;
        if (!hold_start) start = 0;
        for (int i = 0; i < 3 * n + 12; i++) begin
            if (halt_seen) break;
            @(posedge CLK);
        end
        @(negedge CLK);
        if (!halt_seen) fail_evt("halt_timeout");
        else chk("halt_cycle", halt_cyc, 3 * n);
        repeat (3) @(negedge CLK);
        chk("final_acc", acc, exp_acc);
        chk("final_c", carry_flag, exp_c);
        chk("final_z", zero_flag, exp_z);
        chk("final_err", stack_err, exp_err);
        chk("final_halted", halted, 1);
        chk("final_pc", instr_addr, exp_pc);
        chk("fetch_drained", q_fetch.size(), 0);
        chk("alu_drained", q_alu.size(), 0);
        chk("st_drained", q_st.size(), 0);
        start = 0;
    endtask

    initial begin
        int  n;
        bit  h;
        n_cmp  = 0;
        n_bad  = 0;
        mon_en = 0;
        clear_rom();
        do_reset(1);

        // LD/ADD overflow then store and halt
        rom[0] = {OP_LD, 8'hFF}; rom[1] = {OP_ADD, 8'h01}; rom[2] = {OP_ST, 8'h10};
        run_prog(0);
        chk("d28_acc", acc, 8'h00);
        chk("d28_c", carry_flag, 1);
        chk("d28_z", zero_flag, 1);
        chk("d28_cycles", halt_cyc, 12);
        chk("d28_st_cnt", st_cnt, 1);
        chk("d28_st_addr", last_st_addr, 8'h10);
        chk("d28_st_data", last_st_data, 8'h00);
        do_reset(1);

        // call and return
        clear_rom();
        rom[0] = {OP_JMP, 8'h05}; rom[5] = {OP_INC, 8'h00}; rom[6] = {OP_RTN, 8'h00};
        run_prog(1);
        chk("d29_nfetch", obs_fetch.size(), 4);
        if (obs_fetch.size() == 4) begin
            chk("d29_f0", obs_fetch[0], 0);
            chk("d29_f1", obs_fetch[1], 5);
            chk("d29_f2", obs_fetch[2], 6);
            chk("d29_f3", obs_fetch[3], 1);
        end
        chk("d29_acc", acc, 8'h01);
        chk("d29_err", stack_err, 0);
        do_reset(0);

        // stack overflow on the fifth nested JMP
        clear_rom();
        for (int k = 0; k < 5; k++) rom[k] = {OP_JMP, 8'(k + 1)};
        run_prog(0);
        chk("d30_err", stack_err, 1);
        chk("d30_halted", halted, 1);
        chk("d30_pc", instr_addr, 4);
        do_reset(0);

        // stack underflow on the first instruction
        clear_rom();
        rom[0] = {OP_RTN, 8'h00};
        run_prog(0);
        chk("d30b_err", stack_err, 1);
        chk("d30b_pc", instr_addr, 0);
        do_reset(0);

        // SHR of 1 gives zero with carry
        clear_rom();
        rom[0] = {OP_LD, 8'h01}; rom[1] = {OP_SHR, 8'h00};
        run_prog(0);
        chk("d32_acc", acc, 8'h00);
        chk("d32_c", carry_flag, 1);
        chk("d32_z", zero_flag, 1);
        do_reset(0);

        // PC wrap from 0xFF back to 0
        clear_rom();
        rom[0] = {OP_JMP, 8'h10}; rom[8'h10] = {OP_JMP, 8'hFF}; rom[8'hFF] = {OP_NOP, 8'h00};
        run_prog(0);
        if (obs_fetch.size() > 3) begin
            chk("d32_ff", obs_fetch[2], 8'hFF);
            chk("d32_wrap", obs_fetch[3], 0);
        end else fail_evt("d32_fetch_short");
        do_reset(0);

        // reset in the middle of EXECUTE commits nothing
        clear_rom();
        rom[0] = {OP_ADD, 8'h05};
        @(negedge CLK);
        start = 1;
        @(posedge CLK);
        #1;
        start = 0;
        repeat (3) @(negedge CLK);
        chk("d31_ce_exec", alu_CE, 1);
        RST = 1;
        @(negedge CLK);
        RST = 0;
        chk("d31_acc", acc, 0);
        chk("d31_c", carry_flag, 0);
        chk("d31_ce", alu_CE, 0);
        chk("d31_halted", halted, 0);
        repeat (3) @(negedge CLK);
        chk("d31_idle_addr", instr_addr, 0);
        chk("d31_idle_ce", alu_CE, 0);
        run_prog(0);
        chk("d31_rerun_acc", acc, 8'h05);
        do_reset(1);

        for (int t = 0; t < 30; t++) begin
            h = 0;
            for (int tries = 0; tries < 50 && !h; tries++) begin
                gen_random();
                model_run(n, h);
            end
            if (!h) clear_rom();
            run_prog(1'($urandom_range(0, 1)));
            do_reset(t % 5 == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 The block SHALL have parameter SIZE, default 8, data width matching the ALU operand width.
REQ-002 The block SHALL have parameter PC_W, default 8, program-counter and instruction-address width.
REQ-003 The block SHALL have parameter STACK_DEPTH, default 4, return-stack entries.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have these ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous active-high reset.
- start  in  1  begin execution at address 0; sampled only in IDLE.
- instr_addr  out  PC_W  program-ROM address.
- instr_data  in  4+SIZE  ROM word: [SIZE+3:SIZE] opcode, [SIZE-1:0] imm; valid one cycle after instr_addr.
- alu_CE  out  1  ALU chip enable.
- alu_OP_CODE  out  4  ALU opcode.
- alu_left  out  SIZE  accumulator value.
- alu_right  out  SIZE  imm field.
- alu_carry_in  out  1  carry flag.
- alu_op_out  in  SIZE  ALU result.
- alu_carry_out  in  1  ALU carry.
- st_we  out  1  data-store write strobe.
- st_addr  out  SIZE  store address.
- st_data  out  SIZE  store data.
- acc  out  SIZE  accumulator.
- carry_flag  out  1  C flag.
- zero_flag  out  1  Z flag.
- halted  out  1  core stopped.
- stack_err  out  1  sticky return-stack fault.

Function
REQ-006 The block SHALL implement FSM states IDLE, FETCH, DECODE, EXECUTE, HALT.
REQ-007 IDLE->FETCH when start=1; start SHALL be ignored in every other state.
REQ-008 FETCH SHALL drive instr_addr=PC for one cycle, then go to DECODE.
REQ-009 DECODE SHALL latch instr_data into IR, then go to EXECUTE; each instruction takes 3 cycles.
REQ-010 In EXECUTE, alu_CE SHALL be 1 for ADD, SUB, INC, DEC, AND, OR, XOR, NOT, SHL, SHR, LD, and ST; it SHALL be 0 in every other state and opcode.
REQ-011 At the end of EXECUTE for every alu_CE=1 opcode except ST: ACC<=alu_op_out, C<=alu_carry_out, Z<=(alu_op_out==0), PC<=PC+1.
REQ-012 ST SHALL pulse st_we for the EXECUTE cycle with st_addr=imm and st_data=ACC, leave ACC/C/Z unchanged, and set PC<=PC+1.
REQ-013 JMP SHALL push PC+1 onto the return stack and set PC<=imm[PC_W-1:0].
REQ-014 RTN SHALL pop the return stack into PC.
REQ-015 NOP and opcodes not in the shared package SHALL only set PC<=PC+1.
REQ-016 HLT SHALL enter HALT with PC unchanged.
REQ-017 HALT SHALL hold halted=1 and keep all state frozen until RST.
REQ-018 After EXECUTE, the FSM SHALL go to FETCH unless the instruction leads to HALT.
REQ-019 PC SHALL wrap modulo 2^PC_W: PC=max plus 1 gives 0.
REQ-020 A JMP with the stack full SHALL set stack_err=1, enter HALT, and leave PC and the stack unchanged.
REQ-021 An RTN with the stack empty SHALL behave the same as REQ-020.
REQ-022 alu_carry_in SHALL equal C at all times; alu_left SHALL equal ACC; alu_right SHALL equal IR imm.

Reset
REQ-023 RST=1 SHALL force IDLE from any state, including mid-EXECUTE; the in-flight instruction SHALL commit nothing.
REQ-024 Reset values: PC=0, IR=0, ACC=0, C=0, Z=0, stack empty, instr_addr=0, alu_CE=0, st_we=0, halted=0, stack_err=0.

Structure
REQ-025 The FSM state enum and the instruction field positions/widths SHALL be placed in a shared package.
REQ-026 Opcode values SHALL come from the existing shared op-code package and SHALL NOT be redefined locally.
REQ-027 The return stack SHALL be a sub-module ret_stack (STACK_DEPTH x PC_W, push/pop/full/empty).

Verification
REQ-028 ROM: LD 0xFF; ADD 0x01; ST 0x10; HLT; start=1 -> st_we pulse with addr 0x10, data 0x00; ACC=0x00, C=1, Z=1; halted=1 after 12 cycles.
REQ-029 ROM: 0:JMP 0x05; 1:HLT; 5:INC; 6:RTN -> fetch addresses 0,5,6,1; final ACC=0x01; halted=1; stack_err=0.
REQ-030 Five nested JMPs with STACK_DEPTH=4 -> fifth JMP sets stack_err=1 and halted=1, PC = fifth JMP's address. Separately, RTN as the first instruction -> stack_err=1, halted=1.
REQ-031 RST pulsed during EXECUTE of ADD 0x05 with ACC=0 -> ACC=0, C=0, state IDLE, alu_CE=0 on the next cycle; start then refetches from address 0.
REQ-032 NOP at address 0xFF (PC_W=8) -> next instr_addr=0x00. SHR with ACC=0x01 -> ACC=0x00, C=1, Z=1.
